// File: rtl/delay_data_pipe.sv
// delay_data_pipe: DEPTH-stage enable-gated delay line with per-stage valid bits and an occupancy count.
// Define DELAY_PIPE_FLUSH_EN to add a synchronous flush port that clears all valid state.
module delay_data_pipe #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 4,
   localparam int OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] data_in,
   input  logic             valid_in,
`ifdef DELAY_PIPE_FLUSH_EN
   input  logic             flush,
`endif
   output logic [WIDTH-1:0] data_out,
   output logic             valid_out,
   output logic [OCC_W-1:0] occupancy,
   output logic             full
);

   logic             clear;
   logic [WIDTH-1:0] data_q  [DEPTH];
   logic [WIDTH-1:0] data_d  [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic [OCC_W:0]   occ_sum;

`ifdef DELAY_PIPE_FLUSH_EN
   assign clear = flush;
`else
   assign clear = 1'b0;
`endif

   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
         assign data_d[gi]  = data_in;
         assign valid_d[gi] = valid_in;
      end else begin : g_body
         assign data_d[gi]  = data_q[gi-1];
         assign valid_d[gi] = valid_q[gi-1];
      end
   end

   // One extra bit of headroom; the count is bounded 0..DEPTH so truncation is lossless.
   assign occ_sum = {1'b0, occ_q}
                  + {{OCC_W{1'b0}}, valid_in}
                  - {{OCC_W{1'b0}}, valid_q[DEPTH-1]};
   assign occ_d   = occ_sum[OCC_W-1:0];

   // Flush wins over en: valid state clears, data holds and nothing shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
         end
         valid_q <= '0;
         occ_q   <= '0;
      end else if (clear) begin
         valid_q <= '0;
         occ_q   <= '0;
      end else if (en) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
         valid_q <= valid_d;
         occ_q   <= occ_d;
      end
   end

   assign data_out  = data_q[DEPTH-1];
   assign valid_out = valid_q[DEPTH-1];
   assign occupancy = occ_q;
   assign full      = (occ_q == OCC_W'(DEPTH));

endmodule

// File: tb/tb_delay_data_pipe.sv
// Bench for delay_data_pipe at (16,4), (1,1) and (64,32); queue scoreboard plus a vector table.
// Flush checks are included when DELAY_PIPE_FLUSH_EN is defined.
module tb_delay_data_pipe;
   localparam int W0 = 16, D0 = 4;
   localparam int W1 = 1,  D1 = 1;
   localparam int W2 = 64, D2 = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          en0, vin0, fl0, vout0, full0;
   logic [W0-1:0] din0, dout0;
   logic [2:0]    occ0;
   logic          en1, vin1, fl1, vout1, full1;
   logic [W1-1:0] din1, dout1;
   logic [0:0]    occ1;
   logic          en2, vin2, fl2, vout2, full2;
   logic [W2-1:0] din2, dout2;
   logic [5:0]    occ2;

   delay_data_pipe #(.WIDTH(W0), .DEPTH(D0)) u0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .data_in(din0), .valid_in(vin0),
`ifdef DELAY_PIPE_FLUSH_EN
      .flush(fl0),
`endif
      .data_out(dout0), .valid_out(vout0), .occupancy(occ0), .full(full0));

   delay_data_pipe #(.WIDTH(W1), .DEPTH(D1)) u1 (
      .clk(clk), .rst_n(rst_n), .en(en1), .data_in(din1), .valid_in(vin1),
`ifdef DELAY_PIPE_FLUSH_EN
      .flush(fl1),
`endif
      .data_out(dout1), .valid_out(vout1), .occupancy(occ1), .full(full1));

   delay_data_pipe #(.WIDTH(W2), .DEPTH(D2)) u2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .data_in(din2), .valid_in(vin2),
`ifdef DELAY_PIPE_FLUSH_EN
      .flush(fl2),
`endif
      .data_out(dout2), .valid_out(vout2), .occupancy(occ2), .full(full2));

   typedef struct {
      logic [63:0] d;
      logic        v;
   } ent_t;

   // Scoreboard queues: oldest entry is the one currently due on data_out.
   ent_t q0[$];
   ent_t q1[$];
   ent_t q2[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int count_v(input ent_t q[$]);
      int n = 0;
      foreach (q[i]) if (q[i].v) n++;
      return n;
   endfunction

   task automatic reset_models();
      q0.delete(); q1.delete(); q2.delete();
      for (int i = 0; i < D0; i++) q0.push_back('{64'h0, 1'b0});
      for (int i = 0; i < D1; i++) q1.push_back('{64'h0, 1'b0});
      for (int i = 0; i < D2; i++) q2.push_back('{64'h0, 1'b0});
   endtask

   task automatic compare_all();
      chk("u0_data",  {48'h0, dout0}, q0[0].d);
      chk("u0_valid", 64'(vout0), 64'(q0[0].v));
      chk("u0_occ",   64'(occ0), 64'(count_v(q0)));
      chk("u0_full",  64'(full0), 64'(count_v(q0) == D0));
      chk("u1_data",  {63'h0, dout1}, q1[0].d);
      chk("u1_valid", 64'(vout1), 64'(q1[0].v));
      chk("u1_occ",   64'(occ1), 64'(count_v(q1)));
      chk("u1_full",  64'(full1), 64'(count_v(q1) == D1));
      chk("u2_data",  dout2, q2[0].d);
      chk("u2_valid", 64'(vout2), 64'(q2[0].v));
      chk("u2_occ",   64'(occ2), 64'(count_v(q2)));
      chk("u2_full",  64'(full2), 64'(count_v(q2) == D2));
   endtask

   // One clock: drive inputs, advance the models on the edge, compare everything.
   task automatic cycle(input logic e0, input logic v0, input logic [63:0] d0,
                        input logic e1, input logic v1, input logic [63:0] d1,
                        input logic e2, input logic v2, input logic [63:0] d2);
      en0 = e0; vin0 = v0; din0 = d0[W0-1:0];
      en1 = e1; vin1 = v1; din1 = d1[W1-1:0];
      en2 = e2; vin2 = v2; din2 = d2;
      @(posedge clk);
      #1;
      cyc++;
`ifdef DELAY_PIPE_FLUSH_EN
      if (fl0) begin
         foreach (q0[i]) q0[i].v = 1'b0;
      end else
`endif
      if (e0) begin
         q0.push_back('{{48'h0, d0[W0-1:0]}, v0});
         void'(q0.pop_front());
      end
      if (e1) begin
         q1.push_back('{{63'h0, d1[0]}, v1});
         void'(q1.pop_front());
      end
      if (e2) begin
         q2.push_back('{d2, v2});
         void'(q2.pop_front());
      end
      compare_all();
      $display("cyc %0d u0 d=%h v=%b occ=%0d full=%b | u1 d=%b v=%b occ=%0d | u2 v=%b occ=%0d",
               cyc, dout0, vout0, occ0, full0, dout1, vout1, occ1, vout2, occ2);
   endtask

   // Asserts reset between clock edges and checks outputs clear before the next edge.
   task automatic async_reset();
      en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_u0_data",  {48'h0, dout0}, 64'h0);
      chk("rst_u0_valid", 64'(vout0), 64'h0);
      chk("rst_u0_occ",   64'(occ0), 64'h0);
      chk("rst_u0_full",  64'(full0), 64'h0);
      chk("rst_u2_valid", 64'(vout2), 64'h0);
      chk("rst_u2_occ",   64'(occ2), 64'h0);
      reset_models();
      #2 rst_n = 1'b1;
   endtask

   typedef struct {
      logic        en;
      logic        vin;
      logic [15:0] din;
      logic        vout;
      logic [15:0] dout;
      logic [2:0]  occ;
      logic        full;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Bubble pattern 1,0,1,1,0 then idle; outputs lag by DEPTH=4 enabled edges.
      tbl = '{
         '{1'b1, 1'b1, 16'h0010, 1'b0, 16'h0000, 3'd1, 1'b0},
         '{1'b1, 1'b0, 16'h0011, 1'b0, 16'h0000, 3'd1, 1'b0},
         '{1'b1, 1'b1, 16'h0012, 1'b0, 16'h0000, 3'd2, 1'b0},
         '{1'b1, 1'b1, 16'h0013, 1'b1, 16'h0010, 3'd3, 1'b0},
         '{1'b1, 1'b0, 16'h0014, 1'b0, 16'h0011, 3'd2, 1'b0},
         '{1'b1, 1'b0, 16'h0015, 1'b1, 16'h0012, 3'd2, 1'b0},
         '{1'b1, 1'b0, 16'h0016, 1'b1, 16'h0013, 3'd1, 1'b0},
         '{1'b1, 1'b0, 16'h0017, 1'b0, 16'h0014, 3'd0, 1'b0},
         '{1'b1, 1'b0, 16'h0018, 1'b0, 16'h0015, 3'd0, 1'b0}
      };

      rst_n = 1'b0;
      fl0 = 1'b0; fl1 = 1'b0; fl2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en0 = 1'($urandom); vin0 = 1'($urandom); din0 = 16'($urandom);
         en1 = 1'($urandom); vin1 = 1'($urandom); din1 = 1'($urandom);
         en2 = 1'($urandom); vin2 = 1'($urandom); din2 = {$urandom, $urandom};
         @(posedge clk);
         #1;
      end
      chk("hold_rst_data",  {48'h0, dout0}, 64'h0);
      chk("hold_rst_valid", 64'(vout0), 64'h0);
      chk("hold_rst_occ",   64'(occ0), 64'h0);
      chk("hold_rst_full",  64'(full0), 64'h0);
      reset_models();
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].en, tbl[i].vin, {48'h0, tbl[i].din}, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
         chk("tbl_vout", 64'(vout0), 64'(tbl[i].vout));
         chk("tbl_dout", {48'h0, dout0}, {48'h0, tbl[i].dout});
         chk("tbl_occ",  64'(occ0), 64'(tbl[i].occ));
         chk("tbl_full", 64'(full0), 64'(tbl[i].full));
      end

      async_reset();
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 1'b1, 64'(i), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
         if (i == 4) begin
            chk("stream_first_data",  {48'h0, dout0}, 64'h1);
            chk("stream_first_valid", 64'(vout0), 64'h1);
            chk("stream_full_at_4",   64'(full0), 64'h1);
         end
      end
      chk("stream_occ_sat", 64'(occ0), 64'd4);

      async_reset();
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'b1, 64'(16'hA0 + i), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      chk("stall_pre_data", {48'h0, dout0}, 64'hA0);
      for (int i = 0; i < 5; i++)
         cycle(1'b0, 1'($urandom), 64'($urandom), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      chk("stall_hold_data",  {48'h0, dout0}, 64'hA0);
      chk("stall_hold_valid", 64'(vout0), 64'h1);
      cycle(1'b1, 1'b1, 64'hA4, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      chk("stall_resume_data", {48'h0, dout0}, 64'hA1);

`ifdef DELAY_PIPE_FLUSH_EN
      async_reset();
      for (int i = 1; i <= 4; i++)
         cycle(1'b1, 1'b1, 64'(i), 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      chk("flush_pre_full", 64'(full0), 64'h1);
      fl0 = 1'b1;
      cycle(1'b1, 1'b1, 64'hBEEF, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
      fl0 = 1'b0;
      chk("flush_occ",   64'(occ0), 64'h0);
      chk("flush_valid", 64'(vout0), 64'h0);
      chk("flush_full",  64'(full0), 64'h0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0);
         chk("flush_beef_never", 64'(vout0 && (dout0 == 16'hBEEF)), 64'h0);
      end
`endif

      async_reset();
      for (int i = 1; i <= 40; i++) begin
         cycle(1'b0, 1'b0, 64'h0,
               1'b1, 1'b1, 64'(i),
               1'b1, 1'b1, {32'hC0DE0000 + 32'(i), 32'(i)});
         if (i == 1) begin
            chk("d1_first_data",  64'(dout1), 64'h1);
            chk("d1_first_valid", 64'(vout1), 64'h1);
         end
         if (i == 31) chk("d32_not_yet", 64'(vout2), 64'h0);
         if (i == 32) chk("d32_first_data", dout2, {32'hC0DE0001, 32'h1});
      end
      chk("d1_occ_sat",   64'(occ1), 64'h1);
      chk("d32_occ_sat",  64'(occ2), 64'd32);
      chk("d32_full",     64'(full2), 64'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/delay_data_pipe.md
# delay_data_pipe

- Parametrised multi-cycle data delay line with per-stage valid tracking and an occupancy count.
- Replaces the fixed single-cycle 16/24/32-bit delay registers wherever sample streams must be time-aligned across DEPTH cycles, e.g. aligning data with a multi-cycle datapath or with a downstream compute unit.
- Advances only on enable, so the pipeline stalls together with the datapath it aligns.

## Interface
- WIDTH, 16: data width in bits, 1 to 64.
- DEPTH, 4: latency in enabled cycles, 1 to 32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  advance strobe; all stages shift when high.
- data_in  in  WIDTH  input sample.
- valid_in  in  1  qualifies data_in; sampled only when en=1.
- flush  in  1  synchronous clear of valid state; present only with DELAY_PIPE_FLUSH_EN.
- data_out  out  WIDTH  last stage data.
- valid_out  out  1  last stage valid.
- occupancy  out  $clog2(DEPTH+1)  number of stages currently holding valid=1.
- full  out  1  occupancy == DEPTH.

## Operation
- Structure: DEPTH stages, each holding {data, valid}. Stage 0 is the input stage; stage DEPTH-1 drives data_out and valid_out directly, with no extra output register.
- en=1: stage0 <= {data_in, valid_in}, and stage k <= stage k-1 for k ≥ 1.
- en=0: every stage holds. valid_in and data_in are ignored.
- data is registered regardless of valid. Invalid slots carry whatever data_in held; downstream logic must qualify data with valid_out.
- occupancy register, updated only when en=1:
  - next = occupancy + valid_in − valid(stage DEPTH-1).
  - Width rule: the result is computed one bit wider. It never under- or overflows, since it is bounded 0..DEPTH by construction.
- full is combinational from occupancy.
- DEPTH=1 degenerates to a single enabled register. occupancy is then 1 bit and equals valid_out.

## Timing
- Reset (rst_n=0, asynchronous): all stage data = 0, all valid = 0, occupancy = 0. Hence data_out=0, valid_out=0, occupancy=0, full=0.
- Reset release: first active edge is the first clk rising edge with rst_n=1. The release must be synchronised externally.
- Latency: a sample accepted on enabled edge n appears on data_out after enabled edge n+DEPTH-1, i.e. DEPTH enabled edges including the accepting one. Disabled cycles add no shift.
- Continuous en=1: output sample t equals input sample t−DEPTH, so the delay is exactly DEPTH clk cycles.
- Reset asserted mid-stream: all contents are lost immediately. No partial drain.
- valid_out remains asserted while en=0; the sample stays presented until the next enable.
- When occupancy = DEPTH and en=1 with valid_in=1: a sample both enters and leaves, so occupancy stays DEPTH.

## Configuration
- Macro: DELAY_PIPE_FLUSH_EN.
- Defined:
  - flush port exists.
  - flush=1 at a clk edge clears all stage valid bits and sets occupancy to 0. Stage data holds.
  - flush has priority over en. A sample presented with en=1 in the same cycle is dropped, and nothing shifts.
  - valid_out, occupancy and full read 0 the cycle after flush.
- Undefined:
  - No flush port.
  - Valid state is cleared only by rst_n.

## Test plan
- Reset: hold rst_n=0 with random inputs, WIDTH=16, DEPTH=4. Then data_out=0x0000, valid_out=0, occupancy=0 and full=0. Assert rst_n=0 asynchronously mid-cycle; outputs go to 0 before the next edge.
- Continuous stream: en=1, valid_in=1, data_in = 0x0001, 0x0002, … Then 0x0001 appears on data_out with valid_out=1 exactly 4 edges after acceptance. occupancy steps 1, 2, 3, 4, and full=1 from the 4th edge onward.
- Stall: stream 0xA0..0xA3, then en=0 for 5 cycles, then en=1. Then data_out, valid_out and occupancy are frozen during the stall. 0xA0 emerges after the 4th enabled edge, and the stall cycles contribute no latency.
- Bubble tracking: valid_in pattern 1, 0, 1, 1, 0 with en=1. Then valid_out reproduces 1, 0, 1, 1, 0 delayed 4 cycles. occupancy never exceeds 3, and ends at 0 after 4 more cycles with valid_in=0.
- Flush, with DELAY_PIPE_FLUSH_EN: with full=1, assert flush and en together with valid_in=1, data_in=0xBEEF. Then the next cycle has occupancy=0, valid_out=0 and full=0, and 0xBEEF never appears with valid_out=1.
- Parametric: repeat the continuous-stream test at WIDTH=1, DEPTH=1 and at WIDTH=64, DEPTH=32. Then latency equals DEPTH, and occupancy saturates at 1 and at 32 respectively, with no wrap.
